// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write-through bypass, optional zero
// register, per-register busy scoreboard and a registered debug read port.
// Revision: 1.0

`default_nettype none

module regfile_sb #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 5,
  parameter int          ZERO_REG  = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic              clock_in,
  input  logic              rst,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              busy1,
  output logic              busy2,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              setBusy,
  input  logic [ADDR_W-1:0] setReg,
  input  logic [ADDR_W-1:0] showAddress,
  output logic [DATA_W-1:0] display,
  output logic              anyBusy
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(RESET_VAL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_storage
      logic [DATA_W-1:0] q;
      always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
          q <= RST_VAL;
        end else if (regWrite && writeReg == ADDR_W'(i)) begin
          q <= writeData;
        end
      end
      assign mem[i] = q;
    end
  end

  // Set is applied after clear so a same-edge issue to the written register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (regWrite) busy_nxt[writeReg] = 1'b0;
    if (setBusy)  busy_nxt[setReg]   = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      anyBusy <= 1'b0;
      display <= '0;
    end else begin
      busy    <= busy_nxt;
      anyBusy <= |busy_nxt;
      display <= mem[showAddress];
    end
  end

  always_comb begin
    readData1 = mem[readReg1];
    readData2 = mem[readReg2];
    if (regWrite && writeReg == readReg1) readData1 = writeData;
    if (regWrite && writeReg == readReg2) readData2 = writeData;
    if (ZERO_REG != 0 && readReg1 == '0) readData1 = '0;
    if (ZERO_REG != 0 && readReg2 == '0) readData2 = '0;
  end

  // Busy outputs deliberately ignore same-cycle clears; the hazard unit relies on the data bypass.
  assign busy1 = busy[readReg1];
  assign busy2 = busy[readReg2];

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb (default, ZERO_REG=0 and small configs).
// Revision: 1.0

`default_nettype none

module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd1, rd2, wa, sr, sa;
  logic        we, sb;
  logic [31:0] wd;

  logic [31:0] d1, d2, disp;
  logic        b1, b2, anyb;
  logic [31:0] n_d1, n_d2, n_disp;
  logic        n_b1, n_b2, n_anyb;

  logic [2:0]  s_rd1, s_rd2, s_wa, s_sr, s_sa;
  logic        s_we, s_sb;
  logic [7:0]  s_wd, s_d1, s_d2, s_disp;
  logic        s_b1, s_b2, s_anyb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clock_in(clk), .rst(rst), .readReg1(rd1), .readReg2(rd2),
    .readData1(d1), .readData2(d2), .busy1(b1), .busy2(b2),
    .regWrite(we), .writeReg(wa), .writeData(wd), .setBusy(sb), .setReg(sr),
    .showAddress(sa), .display(disp), .anyBusy(anyb)
  );

  regfile_sb #(.ZERO_REG(0)) u_dut_nz (
    .clock_in(clk), .rst(rst), .readReg1(rd1), .readReg2(rd2),
    .readData1(n_d1), .readData2(n_d2), .busy1(n_b1), .busy2(n_b2),
    .regWrite(we), .writeReg(wa), .writeData(wd), .setBusy(sb), .setReg(sr),
    .showAddress(sa), .display(n_disp), .anyBusy(n_anyb)
  );

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .RESET_VAL(1)) u_dut_small (
    .clock_in(clk), .rst(rst), .readReg1(s_rd1), .readReg2(s_rd2),
    .readData1(s_d1), .readData2(s_d2), .busy1(s_b1), .busy2(s_b2),
    .regWrite(s_we), .writeReg(s_wa), .writeData(s_wd), .setBusy(s_sb), .setReg(s_sr),
    .showAddress(s_sa), .display(s_disp), .anyBusy(s_anyb)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rd1 = '0; rd2 = '0; wa = '0; sr = '0; sa = '0; we = 1'b0; sb = 1'b0; wd = '0;
    s_rd1 = '0; s_rd2 = '0; s_wa = '0; s_sr = '0; s_sa = '0; s_we = 1'b0; s_sb = 1'b0; s_wd = '0;
    #3;
    check_val("rst_busy1", {31'b0, b1}, 32'd0);
    check_val("rst_anybusy", {31'b0, anyb}, 32'd0);
    check_val("rst_display", disp, 32'd0);
    check_val("rst_rd1", d1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // parameter sweep: all small regs reset to 1 except the zero register
    for (int i = 0; i < 8; i++) begin
      s_rd1 = 3'(i);
      #1;
      check_val($sformatf("small_rst_r%0d", i), {24'b0, s_d1}, (i == 0) ? 32'd0 : 32'd1);
    end
    s_we = 1'b1; s_wa = 3'd7; s_wd = 8'hAB;
    tick();
    s_we = 1'b0; s_rd1 = 3'd7;
    #1;
    check_val("small_wr_r7", {24'b0, s_d1}, 32'h0000_00AB);

    // write then read
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; rd1 = 5'd5; sa = 5'd5;
    #1;
    check_val("wr_rd_r5", d1, 32'hDEAD_BEEF);
    tick();
    check_val("disp_r5", disp, 32'hDEAD_BEEF);

    // bypass on both ports, display lags the commit
    sa = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'h1234_5678; rd1 = 5'd7; rd2 = 5'd7;
    #1;
    check_val("byp_rd1", d1, 32'h1234_5678);
    check_val("byp_rd2", d2, 32'h1234_5678);
    tick();
    we = 1'b0;
    check_val("disp_r7_old", disp, 32'd0);
    tick();
    check_val("disp_r7_new", disp, 32'h1234_5678);

    // zero register behaviour, with and without ZERO_REG
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; sb = 1'b1; sr = 5'd0; rd1 = 5'd0;
    #1;
    check_val("zero_byp_rd1", d1, 32'd0);
    check_val("nz_byp_rd1", n_d1, 32'hFFFF_FFFF);
    tick();
    we = 1'b0; sb = 1'b0;
    #1;
    check_val("zero_rd1", d1, 32'd0);
    check_val("zero_busy1", {31'b0, b1}, 32'd0);
    check_val("zero_anybusy", {31'b0, anyb}, 32'd0);
    check_val("nz_rd1", n_d1, 32'hFFFF_FFFF);
    check_val("nz_busy1", {31'b0, n_b1}, 32'd1);
    check_val("nz_anybusy", {31'b0, n_anyb}, 32'd1);

    // scoreboard
    sb = 1'b1; sr = 5'd3; rd1 = 5'd3;
    tick();
    sb = 1'b0;
    check_val("sb_set_busy1", {31'b0, b1}, 32'd1);
    check_val("sb_set_any", {31'b0, anyb}, 32'd1);
    sb = 1'b1; sr = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h0000_0033;
    tick();
    check_val("sb_set_wins", {31'b0, b1}, 32'd1);
    sb = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'h0000_0044;
    #1;
    check_val("sb_no_clr_byp", {31'b0, b1}, 32'd1);
    check_val("sb_data_byp", d1, 32'h0000_0044);
    tick();
    we = 1'b0;
    check_val("sb_clr_busy1", {31'b0, b1}, 32'd0);
    check_val("sb_clr_any", {31'b0, anyb}, 32'd0);

    // independent addresses on the same edge
    sb = 1'b1; sr = 5'd4; we = 1'b1; wa = 5'd9; wd = 32'h0000_0099; rd1 = 5'd9; rd2 = 5'd4;
    tick();
    sb = 1'b0; we = 1'b0;
    check_val("ind_busy2", {31'b0, b2}, 32'd1);
    check_val("ind_busy1", {31'b0, b1}, 32'd0);
    check_val("ind_any", {31'b0, anyb}, 32'd1);
    we = 1'b1; wa = 5'd4; wd = 32'h0000_0004;
    tick();
    we = 1'b0;
    check_val("ind_clr_busy2", {31'b0, b2}, 32'd0);
    check_val("ind_clr_any", {31'b0, anyb}, 32'd0);

    // asynchronous reset mid-cycle with a write and setBusy pending
    sb = 1'b1; sr = 5'd10; rd2 = 5'd10;
    tick();
    sb = 1'b0;
    check_val("pre_rst_busy2", {31'b0, b2}, 32'd1);
    sa = 5'd7;
    tick();
    check_val("pre_rst_disp", disp, 32'h1234_5678);
    we = 1'b1; wa = 5'd10; wd = 32'hAAAA_5555; sb = 1'b1; sr = 5'd11; rd1 = 5'd5; rd2 = 5'd11;
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_rd1", d1, 32'd0);
    check_val("arst_busy2", {31'b0, b2}, 32'd0);
    check_val("arst_any", {31'b0, anyb}, 32'd0);
    check_val("arst_disp", disp, 32'd0);
    tick();
    check_val("arst_hold_busy2", {31'b0, b2}, 32'd0);
    check_val("arst_hold_disp", disp, 32'd0);
    @(negedge clk);
    we = 1'b0; sb = 1'b0;
    rst = 1'b0;
    rd1 = 5'd10;
    #1;
    check_val("arst_wr_lost", d1, 32'd0);
    check_val("arst_busy_lost", {31'b0, b2}, 32'd0);
    tick();
    check_val("post_rst_any", {31'b0, anyb}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
